// File: rtl/cubehash_ctrl.sv
// cubehash_ctrl
//   Computes CubeHash r/b-h by driving a combinational CubeHash round into the
//   1024-bit state register, one round per clock. A message is processed in
//   four phases: IV load plus 10r init rounds, per-block absorb (XOR plus r
//   rounds), finalization (x31 ^= 1 plus 10r rounds), and digest hold.
//   Padding and byte packing are done upstream.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         begin a new message (sampled only in IDLE or DONE)
//   busy          high while a message is being hashed
//   blk_valid     upstream has a block on blk_data/blk_last
//   blk_ready     controller can take a block (WAIT_BLK only)
//   blk_data      block; word j = blk_data[BLOCK_BYTES*8-1-32*j -: 32]
//   blk_last      marks the accepted block as the final padded block
//   digest_valid  digest is final (DONE only)
//   digest        top HASH_BITS of the state (words x0, x1, .. from the MSB)
//
// Handshake: a block transfers on a rising edge where blk_valid and blk_ready
// are both high. blk_ready does not depend on blk_valid; blk_valid outside
// WAIT_BLK is ignored and its data is not consumed.

module cubehash_ctrl #(
    parameter int ROUNDS      = 16,
    parameter int BLOCK_BYTES = 32,
    parameter int HASH_BITS   = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    input  logic [BLOCK_BYTES*8-1:0] blk_data,
    input  logic                     blk_last,
    output logic                     digest_valid,
    output logic [HASH_BITS-1:0]     digest
);

    localparam int BLK_BITS    = BLOCK_BYTES * 8;
    localparam int LONG_ROUNDS = 10 * ROUNDS;
    localparam int CNT_W       = $clog2(LONG_ROUNDS);

    localparam logic [CNT_W-1:0] CNT_LONG_END = CNT_W'(LONG_ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_BLK_END  = CNT_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_WAIT_BLK = 3'd2,
        ST_ABSORB   = 3'd3,
        ST_FINAL    = 3'd4,
        ST_DONE     = 3'd5
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [1023:0]     st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;

    logic [1023:0]     round_out;
    logic [1023:0]     blk_ext;
    logic [1023:0]     iv;

    function automatic logic [31:0] rotl7(input logic [31:0] v);
        return {v[24:0], v[31:25]};
    endfunction

    function automatic logic [31:0] rotl11(input logic [31:0] v);
        return {v[20:0], v[31:21]};
    endfunction

    // One CubeHash round. Each stage pair (add, rotate+swap, xor+swap) is
    // folded into a single array-to-array step; the swaps become index XORs.
    function automatic logic [1023:0] cube_round(input logic [1023:0] s);
        logic [31:0] a [32];
        logic [31:0] b [32];
        logic [31:0] c [32];
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) a[i] = s[1023-32*i -: 32];
        for (int i = 0; i < 16; i++) begin
            b[i]      = a[i];
            b[16 + i] = a[16 + i] + a[i];
        end
        for (int i = 0; i < 16; i++) begin
            c[i]      = rotl7(b[i ^ 8]);
            c[16 + i] = b[16 + i];
        end
        for (int i = 0; i < 16; i++) begin
            a[i]      = c[i] ^ c[16 + i];
            a[16 + i] = c[16 + (i ^ 2)];
        end
        for (int i = 0; i < 16; i++) begin
            b[i]      = a[i];
            b[16 + i] = a[16 + i] + a[i];
        end
        for (int i = 0; i < 16; i++) begin
            c[i]      = rotl11(b[i ^ 4]);
            c[16 + i] = b[16 + i];
        end
        for (int i = 0; i < 16; i++) begin
            a[i]      = c[i] ^ c[16 + i];
            a[16 + i] = c[16 + (i ^ 1)];
        end
        r = '0;
        for (int i = 0; i < 32; i++) r[1023-32*i -: 32] = a[i];
        return r;
    endfunction

    always_comb begin
        round_out = cube_round(st_q);

        // Block occupies x0..x(b/4-1); remaining words are left untouched.
        blk_ext = '0;
        blk_ext[1023 -: BLK_BITS] = blk_data;

        iv = '0;
        iv[1023 -: 32] = 32'(HASH_BITS / 8);
        iv[991 -: 32]  = 32'(BLOCK_BYTES);
        iv[959 -: 32]  = 32'(ROUNDS);
    end

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        cnt_d  = cnt_q;
        last_d = last_q;

        unique case (fsm_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    st_d  = iv;
                    cnt_d = '0;
                    fsm_d = ST_INIT;
                end
            end
            ST_INIT: begin
                st_d = round_out;
                if (cnt_q == CNT_LONG_END) begin
                    cnt_d = '0;
                    fsm_d = ST_WAIT_BLK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_BLK: begin
                if (blk_valid) begin
                    st_d   = st_q ^ blk_ext;
                    last_d = blk_last;
                    cnt_d  = '0;
                    fsm_d  = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                st_d = round_out;
                if (cnt_q == CNT_BLK_END) begin
                    cnt_d = '0;
                    if (last_q) begin
                        // Finalization flag lands on x31 after the last absorb round.
                        st_d  = round_out ^ 1024'd1;
                        fsm_d = ST_FINAL;
                    end else begin
                        fsm_d = ST_WAIT_BLK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINAL: begin
                st_d = round_out;
                if (cnt_q == CNT_LONG_END) begin
                    cnt_d = '0;
                    fsm_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            st_q   <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign busy         = (fsm_q == ST_INIT) || (fsm_q == ST_WAIT_BLK) ||
                          (fsm_q == ST_ABSORB) || (fsm_q == ST_FINAL);
    assign blk_ready    = (fsm_q == ST_WAIT_BLK);
    assign digest_valid = (fsm_q == ST_DONE);
    assign digest       = st_q[1023 -: HASH_BITS];

endmodule

// File: tb/tb_cubehash_ctrl.sv
// tb_cubehash_ctrl
//   Bench for cubehash_ctrl at its default parameters (CubeHash16/32-512).
//   A word-array CubeHash model tracks the expected state per message; a
//   compare process checks handshake outputs and the visible state every
//   cycle, and finished digests against an expected queue.

module tb_cubehash_ctrl;

    localparam int R  = 16;
    localparam int BB = 32;
    localparam int HB = 512;
    localparam int BW = BB * 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          blk_valid;
    logic          blk_ready;
    logic [BW-1:0] blk_data;
    logic          blk_last;
    logic          digest_valid;
    logic [HB-1:0] digest;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0]   ms [32];
    logic [HB-1:0] exp_q [$];
    logic [HB-1:0] hold_digest = '0;
    logic          prev_valid  = 1'b0;

    localparam logic [BW-1:0] EMPTY_BLK = {32'h0000_0080, 224'h0};
    localparam logic [BW-1:0] BLK0 = 256'h6162_6364_0102_0304_dead_beef_0bad_f00d_1122_3344_5566_7788_99aa_bbcc_ddee_ff00;
    localparam logic [BW-1:0] BLK1 = 256'hffff_ffff_0000_0001_8000_0000_7fff_ffff_a5a5_a5a5_5a5a_5a5a_0f0f_0f0f_f0f0_f0f0;
    localparam logic [BW-1:0] BLK2 = 256'h0000_8074_6573_7400_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;

    cubehash_ctrl #(
        .ROUNDS      (R),
        .BLOCK_BYTES (BB),
        .HASH_BITS   (HB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_last     (blk_last),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check helper ----------------
    task automatic check(input bit ok, input string name,
                         input logic [HB-1:0] act, input logic [HB-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- CubeHash reference model ----------------
    task automatic swap_words(input int i, input int j);
        logic [31:0] t;
        t     = ms[i];
        ms[i] = ms[j];
        ms[j] = t;
    endtask

    task automatic model_round();
        for (int i = 0; i < 16; i++) ms[i + 16] = ms[i + 16] + ms[i];
        for (int i = 0; i < 16; i++) ms[i] = (ms[i] << 7) | (ms[i] >> 25);
        for (int i = 0; i < 8; i++) swap_words(i, i + 8);
        for (int i = 0; i < 16; i++) ms[i] = ms[i] ^ ms[i + 16];
        for (int i = 16; i < 32; i++) if ((i & 2) == 0) swap_words(i, i + 2);
        for (int i = 0; i < 16; i++) ms[i + 16] = ms[i + 16] + ms[i];
        for (int i = 0; i < 16; i++) ms[i] = (ms[i] << 11) | (ms[i] >> 21);
        for (int i = 0; i < 16; i++) if ((i & 4) == 0) swap_words(i, i + 4);
        for (int i = 0; i < 16; i++) ms[i] = ms[i] ^ ms[i + 16];
        for (int i = 16; i < 32; i += 2) swap_words(i, i + 1);
    endtask

    task automatic model_rounds(input int n);
        for (int k = 0; k < n; k++) model_round();
    endtask

    function automatic logic [HB-1:0] model_top();
        logic [HB-1:0] r;
        r = '0;
        for (int i = 0; i < HB / 32; i++) r[HB-1-32*i -: 32] = ms[i];
        return r;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 32; i++) ms[i] = 32'h0;
        ms[0] = 32'(HB / 8);
        ms[1] = 32'(BB);
        ms[2] = 32'(R);
        model_rounds(10 * R);
    endtask

    task automatic model_absorb(input logic [BW-1:0] d, input bit last);
        for (int j = 0; j < BB / 4; j++) ms[j] = ms[j] ^ d[BW-1-32*j -: 32];
        model_rounds(R);
        if (last) begin
            ms[31] = ms[31] ^ 32'h1;
            model_rounds(10 * R);
            exp_q.push_back(model_top());
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin : compare
        logic [HB-1:0] e;
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (digest_valid && !prev_valid) begin
                check(exp_q.size() != 0, "digest_expected", HB'(exp_q.size()), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check(digest == e, "digest_value", digest, e);
                    hold_digest <= e;
                end
            end else if (digest_valid) begin
                check(digest == hold_digest, "digest_hold", digest, hold_digest);
            end
            if (digest_valid)
                check(!busy && !blk_ready, "done_ctrl", {busy, blk_ready}, 0);
            if (blk_ready) begin
                check(busy && !digest_valid, "wait_ctrl", {busy, digest_valid}, 2'b10);
                check(digest == model_top(), "wait_state", digest, model_top());
            end
            prev_valid <= digest_valid;
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic do_start(output int t0);
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        model_init();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output int t);
        int n;
        n = 0;
        while (!blk_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(blk_ready, "ready_timeout", HB'(blk_ready), 1);
        t = cyc;
    endtask

    task automatic wait_done(output int t);
        int n;
        n = 0;
        while (!digest_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        check(digest_valid, "done_timeout", HB'(digest_valid), 1);
        t = cyc;
    endtask

    // Random traffic that can never be legally taken: blk_valid only while
    // blk_ready is low, start only while busy.
    task automatic junk(input int n);
        for (int k = 0; k < n; k++) begin
            blk_valid = blk_ready ? 1'b0 : 1'($urandom_range(0, 1));
            for (int w = 0; w < BW / 32; w++) blk_data[32*w +: 32] = $urandom;
            blk_last  = 1'($urandom_range(0, 1));
            start     = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        start     = 1'b0;
    endtask

    task automatic send_block(input logic [BW-1:0] d, input bit last,
                              input bit keep_valid, input bit disturb,
                              output int ta);
        int n;
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = last;
        n = 0;
        while (!blk_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(blk_ready, "accept_timeout", HB'(blk_ready), 1);
        ta = cyc;
        @(posedge clk);
        model_absorb(d, last);
        @(negedge clk);
        if (!keep_valid) begin
            blk_valid = 1'b0;
            blk_last  = 1'b0;
        end
        if (disturb) junk(10);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int t0, t1, ta0, ta1, ta2, td;
        logic [HB-1:0] d_empty, d_three;

        rst       = 1'b1;
        start     = 1'b0;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        blk_data  = '0;
        repeat (3) @(negedge clk);
        check(!busy && !blk_ready && !digest_valid, "reset_ctrl",
              {busy, blk_ready, digest_valid}, 0);
        check(digest == '0, "reset_digest", digest, 0);
        rst = 1'b0;
        @(negedge clk);
        check(!busy && !blk_ready && !digest_valid, "idle_ctrl",
              {busy, blk_ready, digest_valid}, 0);

        // IV generation and init latency
        do_start(t0);
        wait_ready(t1);
        check(t1 - t0 == 161, "init_latency", HB'(t1 - t0), 161);
        check(ms[0] == 32'h2AEA2A61, "model_iv_x0", ms[0], 32'h2AEA2A61);
        check(digest[HB-1 -: 32] == 32'h2AEA2A61, "dut_iv_x0", digest[HB-1 -: 32], 32'h2AEA2A61);

        // Empty message
        send_block(EMPTY_BLK, 1'b1, 1'b0, 1'b0, ta0);
        wait_done(td);
        check(td - ta0 == 177, "final_latency", HB'(td - ta0), 177);
        d_empty = digest;

        // Three blocks with blk_valid held high; start issued from DONE
        do_start(t0);
        check(!digest_valid && busy, "restart_valid_drop", {digest_valid, busy}, 2'b01);
        wait_ready(t1);
        send_block(BLK0, 1'b0, 1'b1, 1'b0, ta0);
        send_block(BLK1, 1'b0, 1'b1, 1'b0, ta1);
        send_block(BLK2, 1'b1, 1'b0, 1'b0, ta2);
        check(ta1 - ta0 == 17, "accept_gap_01", HB'(ta1 - ta0), 17);
        check(ta2 - ta1 == 17, "accept_gap_12", HB'(ta2 - ta1), 17);
        wait_done(td);
        check(td - ta2 == 177, "final_latency_3blk", HB'(td - ta2), 177);
        d_three = digest;

        // Same message with stray blk_valid / start traffic while busy
        do_start(t0);
        junk(50);
        wait_ready(t1);
        send_block(BLK0, 1'b0, 1'b0, 1'b1, ta0);
        send_block(BLK1, 1'b0, 1'b0, 1'b1, ta1);
        send_block(BLK2, 1'b1, 1'b0, 1'b1, ta2);
        junk(100);
        wait_done(td);
        check(digest == d_three, "disturbed_digest", digest, d_three);

        // Reset in the middle of ABSORB, then a fresh hash
        do_start(t0);
        wait_ready(t1);
        send_block(BLK0, 1'b0, 1'b0, 1'b0, ta0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check(!busy && !blk_ready && !digest_valid, "midhash_reset_ctrl",
              {busy, blk_ready, digest_valid}, 0);
        check(digest == '0, "midhash_reset_digest", digest, 0);
        rst = 1'b0;
        @(negedge clk);
        do_start(t0);
        wait_ready(t1);
        send_block(BLK1, 1'b0, 1'b0, 1'b0, ta1);
        send_block(BLK2, 1'b1, 1'b0, 1'b0, ta2);
        wait_done(td);

        // Back-to-back: empty message again straight from DONE
        do_start(t0);
        check(!digest_valid, "b2b_valid_drop", HB'(digest_valid), 0);
        wait_ready(t1);
        send_block(EMPTY_BLK, 1'b1, 1'b0, 1'b0, ta0);
        wait_done(td);
        check(digest == d_empty, "b2b_empty_digest", digest, d_empty);

        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "pending_digests", HB'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
